tape_head_ctrl: RTL and testbench

TAPE_HEAD_CTRL -- requirements
Module: tape_head_ctrl

---
 rtl/tape_pkg.sv | 32 +++
 rtl/tape_head_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tape_head_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// rtl/tape_pkg.sv - shared state encoding and move codes for tape_head_ctrl
//
// Purpose : Constants shared by the tape head controller and its bench.
//           The FSM state encoding is a set of plain localparam constants
//           so that older tools and waveform viewers see simple vectors.
// Contents: STATE_W         width of the FSM state register
//           ST_*            FSM state codes
//           MOVE_*          2-bit head move codes carried on cmd_move
//           move_is_stay()  true when a move code leaves the head in place

package tape_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_INIT_FETCH = 3'd0;
  localparam logic [STATE_W-1:0] ST_INIT_CAP   = 3'd1;
  localparam logic [STATE_W-1:0] ST_IDLE       = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITE      = 3'd3;
  localparam logic [STATE_W-1:0] ST_FETCH      = 3'd4;
  localparam logic [STATE_W-1:0] ST_CAPTURE    = 3'd5;
  localparam logic [STATE_W-1:0] ST_RESP       = 3'd6;

  localparam logic [1:0] MOVE_STAY  = 2'b00;
  localparam logic [1:0] MOVE_LEFT  = 2'b01;
  localparam logic [1:0] MOVE_RIGHT = 2'b10;
  localparam logic [1:0] MOVE_HOME  = 2'b11;

  function automatic logic move_is_stay(input logic [1:0] move);
    return move == MOVE_STAY;
  endfunction

endpackage

// File: rtl/tape_head_ctrl.sv
// rtl/tape_head_ctrl.sv - read/write head controller for an external tape RAM
//
// Purpose : Keeps a head position on a circular tape held in an external
//           synchronous RAM. Each accepted command optionally writes a
//           symbol at the current cell, then moves the head (stay, left,
//           right or home) and answers with the symbol now under the head
//           and the new position. The symbol under the head is cached in
//           r_cur_sym so a stay without a write needs no RAM access.
//
// Ports   : clk        in   sole clock, rising edge
//           rst        in   synchronous active-high reset
//           cmd_valid  in   command offered
//           cmd_ready  out  block idle and able to accept a command
//           cmd_write  in   write cmd_sym at the current cell before moving
//           cmd_sym    in   [DATA_WIDTH] symbol to write
//           cmd_move   in   [2] move code (tape_pkg MOVE_*)
//           rsp_valid  out  response available
//           rsp_ready  in   consumer takes the response
//           rsp_sym    out  [DATA_WIDTH] symbol under the head after the move
//           rsp_pos    out  [ADDR_SPACE] head position after the move
//           mem_addr   out  [ADDR_SPACE] RAM address
//           mem_data   out  [DATA_WIDTH] RAM write data
//           mem_we     out  RAM write enable
//           mem_rdata  in   [DATA_WIDTH] RAM read data, one cycle after address

module tape_head_ctrl
  import tape_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SPACE = 14,
  parameter int HOME_ADDR  = 2 ** (ADDR_SPACE - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_sym,
  input  logic [1:0]            cmd_move,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_sym,
  output logic [ADDR_SPACE-1:0] rsp_pos,
  output logic [ADDR_SPACE-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_SPACE-1:0] HOME_POS = ADDR_SPACE'(HOME_ADDR);
  localparam logic [ADDR_SPACE-1:0] POS_ONE  = ADDR_SPACE'(1);

  logic [STATE_W-1:0]    r_state;
  logic [ADDR_SPACE-1:0] r_pos;
  logic [DATA_WIDTH-1:0] r_cur_sym;
  logic                  r_cmd_write;
  logic [DATA_WIDTH-1:0] r_cmd_sym;
  logic [1:0]            r_cmd_move;
  logic [DATA_WIDTH-1:0] r_mem_data;

  logic                  w_accept;

  // Head arithmetic wraps naturally in ADDR_SPACE bits: 0-1 is all-ones
  // and all-ones+1 is 0, which gives the circular tape.
  function automatic logic [ADDR_SPACE-1:0] next_pos(
    input logic [ADDR_SPACE-1:0] pos,
    input logic [1:0]            move
  );
    logic [ADDR_SPACE-1:0] result;
    case (move)
      MOVE_LEFT:  result = pos - POS_ONE;
      MOVE_RIGHT: result = pos + POS_ONE;
      MOVE_HOME:  result = HOME_POS;
      default:    result = pos;
    endcase
    return result;
  endfunction

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_sym   = r_cur_sym;
  assign rsp_pos   = r_pos;

  // A writing command keeps r_pos unchanged until the end of WRITE, so
  // r_pos is still the old position while the write is on the bus.
  assign mem_addr  = r_pos;
  assign mem_data  = r_mem_data;

  // Gated with rst so a reset landing in WRITE never reaches the RAM.
  assign mem_we    = (r_state == ST_WRITE) && r_cmd_write && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT_FETCH;
      r_pos       <= HOME_POS;
      r_cur_sym   <= '0;
      r_cmd_write <= 1'b0;
      r_cmd_sym   <= '0;
      r_cmd_move  <= MOVE_STAY;
      r_mem_data  <= '0;
    end else begin
      case (r_state)
        ST_INIT_FETCH: begin
          r_state <= ST_INIT_CAP;
        end

        ST_INIT_CAP: begin
          r_cur_sym <= mem_rdata;
          r_state   <= ST_IDLE;
        end

        ST_IDLE: begin
          if (w_accept) begin
            r_cmd_write <= cmd_write;
            r_cmd_sym   <= cmd_sym;
            r_cmd_move  <= cmd_move;
            if (cmd_write) begin
              // Write data is loaded here and then held, so mem_data keeps
              // the last written symbol outside WRITE.
              r_mem_data <= cmd_sym;
              r_state    <= ST_WRITE;
            end else begin
              r_pos <= next_pos(r_pos, cmd_move);
              if (move_is_stay(cmd_move)) begin
                // Cached symbol is already the one under the head.
                r_state <= ST_RESP;
              end else begin
                r_state <= ST_FETCH;
              end
            end
          end
        end

        ST_WRITE: begin
          // For write+stay the written symbol is the answer; for write+move
          // this value is replaced in CAPTURE.
          r_cur_sym <= r_cmd_sym;
          r_pos     <= next_pos(r_pos, r_cmd_move);
          if (move_is_stay(r_cmd_move)) begin
            r_state <= ST_RESP;
          end else begin
            r_state <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          // A home move from HOME_ADDR still comes through here and re-reads.
          r_state <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          r_cur_sym <= mem_rdata;
          r_state   <= ST_RESP;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_INIT_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tape_head_ctrl.sv
// tb/tb_tape_head_ctrl.sv - self-checking bench for tape_head_ctrl

module tb_tape_head_ctrl;
  import tape_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 4;
  localparam int HOME = 8;
  localparam int N    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [DW-1:0] cmd_sym;
  logic [1:0]    cmd_move;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_sym;
  logic [AW-1:0] rsp_pos;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [N];
  logic          preload;

  logic [DW-1:0] mref [N];
  int            mpos;

  int n_cmp = 0;
  int n_err = 0;

  tape_head_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_SPACE(AW),
    .HOME_ADDR (HOME)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_sym  (cmd_sym),
    .cmd_move (cmd_move),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sym  (rsp_sym),
    .rsp_pos  (rsp_pos),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Registered-read RAM, read-before-write; preload gives mem[i]=i.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < N; i++) ram[i] <= DW'(i);
    end else begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // Reference model: tape as an array, head as an integer, modulo N.
  task automatic model_cmd(input logic w, input logic [DW-1:0] s, input logic [1:0] m,
                           output logic [DW-1:0] e_sym, output int e_pos, output int e_lat,
                           output int e_waddr);
    e_waddr = mpos;
    if (w) mref[mpos] = s;
    case (m)
      MOVE_LEFT:  mpos = (mpos + N - 1) % N;
      MOVE_RIGHT: mpos = (mpos + 1) % N;
      MOVE_HOME:  mpos = HOME;
      default:    mpos = mpos;
    endcase
    e_pos = mpos;
    e_sym = mref[mpos];
    e_lat = 1 + (w ? 1 : 0) + ((m != MOVE_STAY) ? 2 : 0);
  endtask

  // Stimulus driver: issues one command, measures latency and write pulses.
  task automatic do_cmd(input logic w, input logic [DW-1:0] s, input logic [1:0] m,
                        output int lat, output logic [DW-1:0] rs, output logic [AW-1:0] rp,
                        output int wec, output logic [AW-1:0] wa, output logic [DW-1:0] wd,
                        output logic ok);
    ok = 1'b0; lat = 0; wec = 0; wa = '0; wd = '0; rs = '0; rp = '0;
    for (int k = 0; k < 20 && !cmd_ready; k++) begin @(posedge clk); #1; end
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_write = w; cmd_sym = s; cmd_move = m;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (mem_we) begin wec++; wa = mem_addr; wd = mem_data; end
      @(posedge clk); #1;
      lat++;
    end
    if (mem_we) wec++;
    if (!rsp_valid) return;
    rs = rsp_sym; rp = rsp_pos; ok = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    preload = 1'b1; rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sym = '0; cmd_move = MOVE_STAY; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b required 0", mem_we); end
    n_cmp++; if (mem_data !== 8'h00) begin n_err++; $display("FAIL reset_mem_data: got %h required 00", mem_data); end
    n_cmp++; if (rsp_pos !== 4'd8) begin n_err++; $display("FAIL reset_pos: got %0d required 8", rsp_pos); end
    for (int i = 0; i < N; i++) mref[i] = DW'(i);
    mpos = HOME;
    preload = 1'b0; rst = 1'b0;
    n_cmp++; if (mem_addr !== 4'd8) begin n_err++; $display("FAIL init_fetch_addr: got %0d required 8", mem_addr); end
    @(posedge clk); #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL init_cap_ready: got %b required 0", cmd_ready); end
    @(posedge clk); #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_third_cycle: got %b required 1", cmd_ready); end
  endtask

  task automatic test_stay;
    int lat, wec, ep, el, ewa; logic [DW-1:0] rs, wd, es; logic [AW-1:0] rp, wa; logic ok;
    model_cmd(1'b0, 8'h3C, MOVE_STAY, es, ep, el, ewa);
    do_cmd(1'b0, 8'h3C, MOVE_STAY, lat, rs, rp, wec, wa, wd, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL stay_timeout: got %b required 1", ok); end
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL stay_latency: got %0d required 1", lat); end
    n_cmp++; if (rs !== 8'h08 || rp !== 4'd8) begin n_err++; $display("FAIL stay_rsp: got sym %h pos %0d required 08 8", rs, rp); end
    n_cmp++; if (wec != 0) begin n_err++; $display("FAIL stay_no_write: got %0d required 0", wec); end
  endtask

  task automatic test_write_right;
    int lat, wec, ep, el, ewa; logic [DW-1:0] rs, wd, es; logic [AW-1:0] rp, wa; logic ok;
    model_cmd(1'b1, 8'hA5, MOVE_RIGHT, es, ep, el, ewa);
    do_cmd(1'b1, 8'hA5, MOVE_RIGHT, lat, rs, rp, wec, wa, wd, ok);
    n_cmp++; if (wec != 1) begin n_err++; $display("FAIL wr_we_pulses: got %0d required 1", wec); end
    n_cmp++; if (wa !== 4'd8 || wd !== 8'hA5) begin n_err++; $display("FAIL wr_bus: got addr %0d data %h required 8 a5", wa, wd); end
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL wr_latency: got %0d required 4", lat); end
    n_cmp++; if (rs !== 8'h09 || rp !== 4'd9) begin n_err++; $display("FAIL wr_rsp: got sym %h pos %0d required 09 9", rs, rp); end
    n_cmp++; if (mem_data !== 8'hA5) begin n_err++; $display("FAIL wr_data_hold: got %h required a5", mem_data); end
  endtask

  task automatic test_left;
    int lat, wec, ep, el, ewa; logic [DW-1:0] rs, wd, es; logic [AW-1:0] rp, wa; logic ok;
    model_cmd(1'b0, 8'h00, MOVE_LEFT, es, ep, el, ewa);
    do_cmd(1'b0, 8'h00, MOVE_LEFT, lat, rs, rp, wec, wa, wd, ok);
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL left_latency: got %0d required 3", lat); end
    n_cmp++; if (rs !== 8'hA5 || rp !== 4'd8) begin n_err++; $display("FAIL left_rsp: got sym %h pos %0d required a5 8", rs, rp); end
  endtask

  task automatic test_wrap;
    int lat, wec, ep, el, ewa; logic [DW-1:0] rs, wd, es; logic [AW-1:0] rp, wa; logic ok;
    for (int i = 0; i < 8; i++) begin
      model_cmd(1'b0, 8'h00, MOVE_LEFT, es, ep, el, ewa);
      do_cmd(1'b0, 8'h00, MOVE_LEFT, lat, rs, rp, wec, wa, wd, ok);
      n_cmp++; if (rp !== AW'(ep) || rs !== es) begin n_err++; $display("FAIL walk_left: got pos %0d sym %h required %0d %h", rp, rs, ep, es); end
    end
    model_cmd(1'b0, 8'h00, MOVE_LEFT, es, ep, el, ewa);
    do_cmd(1'b0, 8'h00, MOVE_LEFT, lat, rs, rp, wec, wa, wd, ok);
    n_cmp++; if (rp !== 4'd15 || rs !== 8'h0F) begin n_err++; $display("FAIL wrap_left: got pos %0d sym %h required 15 0f", rp, rs); end
    model_cmd(1'b0, 8'h00, MOVE_RIGHT, es, ep, el, ewa);
    do_cmd(1'b0, 8'h00, MOVE_RIGHT, lat, rs, rp, wec, wa, wd, ok);
    n_cmp++; if (rp !== 4'd0 || rs !== 8'h00) begin n_err++; $display("FAIL wrap_right: got pos %0d sym %h required 0 00", rp, rs); end
  endtask

  task automatic test_home;
    int lat, wec, ep, el, ewa; logic [DW-1:0] rs, wd, es; logic [AW-1:0] rp, wa; logic ok;
    for (int i = 0; i < 2; i++) begin
      model_cmd(1'b0, 8'h00, MOVE_HOME, es, ep, el, ewa);
      do_cmd(1'b0, 8'h00, MOVE_HOME, lat, rs, rp, wec, wa, wd, ok);
      n_cmp++; if (lat != 3) begin n_err++; $display("FAIL home_latency: got %0d required 3", lat); end
      n_cmp++; if (rp !== 4'd8 || rs !== 8'hA5) begin n_err++; $display("FAIL home_rsp: got pos %0d sym %h required 8 a5", rp, rs); end
    end
  endtask

  task automatic test_write_stay;
    int lat, wec, ep, el, ewa; logic [DW-1:0] rs, wd, es; logic [AW-1:0] rp, wa; logic ok;
    model_cmd(1'b1, 8'h5A, MOVE_STAY, es, ep, el, ewa);
    do_cmd(1'b1, 8'h5A, MOVE_STAY, lat, rs, rp, wec, wa, wd, ok);
    n_cmp++; if (lat != 2) begin n_err++; $display("FAIL wstay_latency: got %0d required 2", lat); end
    n_cmp++; if (rs !== 8'h5A || rp !== 4'd8) begin n_err++; $display("FAIL wstay_rsp: got sym %h pos %0d required 5a 8", rs, rp); end
    n_cmp++; if (ram[8] !== 8'h5A) begin n_err++; $display("FAIL wstay_cell: got %h required 5a", ram[8]); end
  endtask

  task automatic test_backpressure;
    int ep, el, ewa; logic [DW-1:0] es;
    for (int k = 0; k < 20 && !cmd_ready; k++) begin @(posedge clk); #1; end
    model_cmd(1'b0, 8'h00, MOVE_STAY, es, ep, el, ewa);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_move = MOVE_STAY;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sym = 8'hFF; cmd_move = MOVE_RIGHT;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_sym !== es || rsp_pos !== AW'(ep))
        begin n_err++; $display("FAIL bp_hold: got v %b sym %h pos %0d required 1 %h %0d", rsp_valid, rsp_sym, rsp_pos, es, ep); end
      n_cmp++; if (cmd_ready !== 1'b0 || mem_we !== 1'b0)
        begin n_err++; $display("FAIL bp_no_accept: got ready %b we %b required 0 0", cmd_ready, mem_we); end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_pos !== AW'(ep))
      begin n_err++; $display("FAIL bp_release: got ready %b valid %b pos %0d required 1 0 %0d", cmd_ready, rsp_valid, rsp_pos, ep); end
    n_cmp++; if (ram[ep] !== mref[ep]) begin n_err++; $display("FAIL bp_cell: got %h required %h", ram[ep], mref[ep]); end
  endtask

  task automatic test_random;
    int lat, wec, ep, el, ewa; logic [DW-1:0] rs, wd, es; logic [AW-1:0] rp, wa; logic ok;
    logic w; logic [DW-1:0] s; logic [1:0] m;
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1)); s = 8'($urandom); m = 2'($urandom_range(0, 3));
      model_cmd(w, s, m, es, ep, el, ewa);
      do_cmd(w, s, m, lat, rs, rp, wec, wa, wd, ok);
      n_cmp++; if (lat != el || rs !== es || rp !== AW'(ep))
        begin n_err++; $display("FAIL rand_rsp[%0d]: got lat %0d sym %h pos %0d required %0d %h %0d", i, lat, rs, rp, el, es, ep); end
      n_cmp++; if (wec != (w ? 1 : 0)) begin n_err++; $display("FAIL rand_we[%0d]: got %0d required %0d", i, wec, w); end
      if (w) begin
        n_cmp++; if (wa !== AW'(ewa) || wd !== s)
          begin n_err++; $display("FAIL rand_wbus[%0d]: got addr %0d data %h required %0d %h", i, wa, wd, ewa, s); end
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++; if (ram[i] !== mref[i]) begin n_err++; $display("FAIL rand_ram[%0d]: got %h required %h", i, ram[i], mref[i]); end
    end
  endtask

  task automatic test_reset_during_write;
    int lat, wec, ep, el, ewa, p, nv; logic [DW-1:0] rs, wd, es; logic [AW-1:0] rp, wa; logic ok;
    if (mpos == HOME) begin
      model_cmd(1'b0, 8'h00, MOVE_RIGHT, es, ep, el, ewa);
      do_cmd(1'b0, 8'h00, MOVE_RIGHT, lat, rs, rp, wec, wa, wd, ok);
    end
    p = mpos;
    for (int k = 0; k < 20 && !cmd_ready; k++) begin @(posedge clk); #1; end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sym = ~mref[p]; cmd_move = MOVE_RIGHT;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'b0;
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL rw_in_write: got %b required 1", mem_we); end
    rst = 1'b1; #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rw_we_gated: got %b required 0", mem_we); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mpos = HOME;
    n_cmp++; if (mem_addr !== 4'd8) begin n_err++; $display("FAIL rw_reread_addr: got %0d required 8", mem_addr); end
    nv = 0;
    for (int c = 0; c < 4; c++) begin if (rsp_valid) nv++; @(posedge clk); #1; end
    n_cmp++; if (nv != 0) begin n_err++; $display("FAIL rw_no_rsp: got %0d required 0", nv); end
    n_cmp++; if (ram[p] !== mref[p]) begin n_err++; $display("FAIL rw_cell: got %h required %h", ram[p], mref[p]); end
    model_cmd(1'b0, 8'h00, MOVE_STAY, es, ep, el, ewa);
    do_cmd(1'b0, 8'h00, MOVE_STAY, lat, rs, rp, wec, wa, wd, ok);
    n_cmp++; if (rp !== 4'd8 || rs !== es || lat != 1)
      begin n_err++; $display("FAIL rw_after: got pos %0d sym %h lat %0d required 8 %h 1", rp, rs, lat, es); end
  endtask

  initial begin
    test_reset();
    test_stay();
    test_write_right();
    test_left();
    test_wrap();
    test_home();
    test_write_stay();
    test_backpressure();
    test_random();
    test_reset_during_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
